sdram_access_arbiter: RTL and testbench
=======================================

Name: sdram_access_arbiter

Overview:
- Shares the single PSRAM/SDRAM controller command port between two burst requesters: the camera frame loader (write) and the display fetcher (read).
- Sits between the VideoController datapaths and the memory IP, in the fb_clk domain.
- Sequences one burst at a time: grant, command pulse, data phase, mandatory recovery gap.
- Read priority, with a starvation bound for writes; sticky error on read timeout.

Parameters:
- MEMORY_BURST, 32, burst length in bytes; BURST_WORDS = MEMORY_BURST/4 32-bit words (8 at default).
- CMD_CYCLES, 19, minimum cycles from one cmd_en to the next cmd_en (must be ≥ BURST_WORDS+1).
- READ_TIMEOUT, 64, maximum cycles from read cmd_en to the first rd_data_valid.
- MAX_READ_STREAK, 4, consecutive read grants allowed while a write is pending.
- ADDR_WIDTH, 21, memory address width.

Ports:
- clk  in  1  fb_clk domain clock
- rst  in  1  synchronous active-high reset
- init_done  in  1  memory controller calibrated
- wr_req  in  1  write burst request; hold with wr_addr until wr_gnt
- wr_addr  in  ADDR_WIDTH  write burst start address
- wr_gnt  out  1  one-cycle pulse, coincident with write cmd_en
- wr_data_in  in  32  current write word, passed combinationally to mem_wr_data
- wr_data_next  out  1  high each cycle a word is consumed; requester advances its word on the next edge
- rd_req  in  1  read burst request; hold with rd_addr until rd_gnt
- rd_addr  in  ADDR_WIDTH  read burst start address
- rd_gnt  out  1  one-cycle pulse, coincident with read cmd_en
- rd_data_out  out  32  registered read word
- rd_data_out_valid  out  1  registered rd_data_valid, qualifies rd_data_out
- rd_burst_done  out  1  one-cycle pulse after the last read word
- mem_cmd  out  1  1 = write, 0 = read
- mem_cmd_en  out  1  command strobe, one cycle
- mem_addr  out  ADDR_WIDTH  command address
- mem_wr_data  out  32  = wr_data_in
- mem_data_mask  out  4  always 4'b0000
- mem_rd_data  in  32  read data from controller
- mem_rd_data_valid  in  1  read data strobe from controller
- error  out  1  sticky read-timeout flag

Behaviour:
- Reset: all outputs 0, state INIT_WAIT, streak counter 0, error 0. Reset mid-burst aborts immediately; no further cmd_en is issued.
- INIT_WAIT: stay until init_done=1, then go to IDLE.
- IDLE arbitration, evaluated every cycle:
  - If rd_req and (!wr_req or streak < MAX_READ_STREAK): grant read.
  - Else if wr_req: grant write.
- Grant cycle:
  - mem_cmd_en=1, mem_addr=granted address, matching *_gnt=1, mem_cmd set for the burst and held until the next grant.
  - Cycle counter loaded with CMD_CYCLES-1.
- Streak counter:
  - Increments on a read grant while wr_req=1.
  - Clears on any write grant, or when wr_req=0 at a read grant.
- WR_BURST:
  - wr_data_next=1 for exactly BURST_WORDS cycles, starting at the grant cycle, so word 0 is on the bus with cmd_en.
  - Then go to GAP.
- RD_WAIT:
  - Wait for mem_rd_data_valid; the first valid goes to RD_BURST.
  - If READ_TIMEOUT cycles elapse with no valid: set error, go to GAP.
- RD_BURST:
  - Each valid is registered to rd_data_out / rd_data_out_valid (1-cycle latency) and counted.
  - After BURST_WORDS words, pulse rd_burst_done and go to GAP.
  - Valid strobes outside RD_WAIT/RD_BURST are ignored.
- GAP: idle until the counter reaches 0, then go to IDLE. Consecutive cmd_en pulses are never closer than CMD_CYCLES.
- init_done falling: finish the current state sequence, then return to INIT_WAIT instead of IDLE.
- Requests asserted during a busy state are held by the requester and not lost. A request dropped before its grant is not serviced.
- Address arithmetic: none; the address is passed through and latched at grant.

Decomposition:
- Shared package sdram_arb_pkg:
  - state enum: INIT_WAIT, IDLE, WR_BURST, RD_WAIT, RD_BURST, GAP.
  - CMD_WRITE=1, CMD_READ=0.
  - Function burst_words(MEMORY_BURST).
- No sub-module; the cycle counter and streak counter stay inline.

Test Plan:
- init_done=0, wr_req=1 for 50 cycles -> no cmd_en; after init_done=1, cmd_en with mem_cmd=1 on the next cycle.
- wr_req, wr_addr=21'h096040, words 0..7 = 32'hA0..A7 -> cmd_en + wr_gnt together; 8 consecutive wr_data_next; mem_wr_data sequence A0..A7; next cmd_en no earlier than 19 cycles later.
- Read request, controller returns 8 valids starting 5 cycles after cmd_en, with gaps -> 8 rd_data_out_valid pulses one cycle after each; rd_burst_done after the 8th.
- rd_req and wr_req held continuously -> grant order R,R,R,R,W,R,R,R,R,W; cmd_en spacing exactly 19 at minimum.
- Read with no rd_data_valid -> error=1 at cycle 64 after cmd_en; next grant proceeds; error stays 1 until rst.
- rst asserted during the 4th write word -> all outputs 0 next cycle, state INIT_WAIT, no extra cmd_en.

Source files
------------

// File: rtl/sdram_access_arbiter_pkg.sv
// Shared types and helpers for the fb_clk-domain SDRAM/PSRAM access arbiter.
package sdram_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    IDLE      = 3'd1,
    WR_BURST  = 3'd2,
    RD_WAIT   = 3'd3,
    RD_BURST  = 3'd4,
    GAP       = 3'd5
  } arb_state_t;

  // Encoding of mem_cmd.
  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  // Number of 32-bit words in a burst of the given byte length.
  function automatic int burst_words(input int memory_burst);
    return memory_burst / 4;
  endfunction

endpackage

// File: rtl/sdram_access_arbiter.sv
// Shares one memory-controller command port between the camera frame loader
// (write bursts) and the display fetcher (read bursts). One burst at a time:
// grant + command pulse, data phase, then a recovery gap so that command
// strobes are never closer than CMD_CYCLES. Reads win arbitration unless a
// waiting write has already been passed over MAX_READ_STREAK times.
//
// Handshake: a requester raises *_req with a stable *_addr and holds both
// until it sees the one-cycle *_gnt pulse; dropping *_req earlier withdraws
// the request. Write words are consumed one per cycle while wr_data_next is
// high, the requester presents the next word after each such edge. Read words
// are qualified solely by rd_data_out_valid; there is no backpressure.
module sdram_access_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int MEMORY_BURST    = 32,
  parameter int CMD_CYCLES      = 19,
  parameter int READ_TIMEOUT    = 64,
  parameter int MAX_READ_STREAK = 4,
  parameter int ADDR_WIDTH      = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_gnt,
  input  logic [31:0]           wr_data_in,
  output logic                  wr_data_next,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [31:0]           rd_data_out,
  output logic                  rd_data_out_valid,
  output logic                  rd_burst_done,
  output logic                  mem_cmd,
  output logic                  mem_cmd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wr_data,
  output logic [3:0]            mem_data_mask,
  input  logic [31:0]           mem_rd_data,
  input  logic                  mem_rd_data_valid,
  output logic                  error,
  output arb_state_t            dbg_state
);

  localparam int BURST_WORDS = burst_words(MEMORY_BURST);

  localparam int CYC_W = (CMD_CYCLES > 2) ? $clog2(CMD_CYCLES) : 1;
  localparam int TO_W  = (READ_TIMEOUT > 2) ? $clog2(READ_TIMEOUT) : 1;
  localparam int WC_W  = $clog2(BURST_WORDS + 1);
  localparam int ST_W  = $clog2(MAX_READ_STREAK + 1);

  localparam logic [CYC_W-1:0] CYC_LOAD  = CYC_W'(CMD_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [CYC_W-1:0] CYC_ZERO  = '0;
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(READ_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(BURST_WORDS);
  localparam logic [WC_W-1:0]  WC_PENULT = WC_W'(BURST_WORDS - 1);
  localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
  localparam logic [ST_W-1:0]  ST_MAX    = ST_W'(MAX_READ_STREAK);
  localparam logic [ST_W-1:0]  ST_ONE    = ST_W'(1);

  arb_state_t       state;
  logic [CYC_W-1:0] cyc_cnt;    // cycles left until the next command may issue
  logic [TO_W-1:0]  to_cnt;     // cycles spent waiting for the first read word
  logic [WC_W-1:0]  word_cnt;   // words moved in the current burst
  logic [ST_W-1:0]  streak;     // read grants issued while a write was waiting
  logic             grant_rd;
  logic             grant_wr;

  // Write data and mask are pure pass-through; the controller samples them
  // on the edges where wr_data_next is high.
  assign mem_wr_data   = wr_data_in;
  assign mem_data_mask = 4'b0000;
  assign dbg_state     = state;

  // Arbitration decision for the current IDLE cycle.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state == IDLE && init_done) begin
      if (rd_req && (!wr_req || streak < ST_MAX)) begin
        grant_rd = 1'b1;
      end else if (wr_req) begin
        grant_wr = 1'b1;
      end
    end
  end

  // Burst sequencer with registered command, grant and read-data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= INIT_WAIT;
      cyc_cnt           <= '0;
      to_cnt            <= '0;
      word_cnt          <= '0;
      streak            <= '0;
      wr_gnt            <= 1'b0;
      rd_gnt            <= 1'b0;
      wr_data_next      <= 1'b0;
      rd_data_out       <= '0;
      rd_data_out_valid <= 1'b0;
      rd_burst_done     <= 1'b0;
      mem_cmd           <= 1'b0;
      mem_cmd_en        <= 1'b0;
      mem_addr          <= '0;
      error             <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state below re-asserts them.
      mem_cmd_en        <= 1'b0;
      wr_gnt            <= 1'b0;
      rd_gnt            <= 1'b0;
      rd_data_out_valid <= 1'b0;
      rd_burst_done     <= 1'b0;

      // The command-spacing counter runs freely from each grant.
      if (cyc_cnt != CYC_ZERO) begin
        cyc_cnt <= cyc_cnt - CYC_ONE;
      end

      case (state)
        INIT_WAIT: begin
          if (init_done) begin
            state <= IDLE;
          end
        end

        IDLE: begin
          if (!init_done) begin
            state <= INIT_WAIT;
          end else if (grant_rd) begin
            mem_cmd_en <= 1'b1;
            rd_gnt     <= 1'b1;
            mem_cmd    <= CMD_READ;
            mem_addr   <= rd_addr;
            cyc_cnt    <= CYC_LOAD;
            to_cnt     <= '0;
            word_cnt   <= '0;
            // Only reads that overtake a waiting write count toward the bound.
            streak     <= wr_req ? (streak + ST_ONE) : '0;
            state      <= RD_WAIT;
          end else if (grant_wr) begin
            mem_cmd_en   <= 1'b1;
            wr_gnt       <= 1'b1;
            mem_cmd      <= CMD_WRITE;
            mem_addr     <= wr_addr;
            cyc_cnt      <= CYC_LOAD;
            // Word 0 is consumed in the grant cycle itself.
            wr_data_next <= 1'b1;
            word_cnt     <= WC_ONE;
            streak       <= '0;
            state        <= WR_BURST;
          end
        end

        WR_BURST: begin
          if (word_cnt == WC_LAST) begin
            wr_data_next <= 1'b0;
            state        <= GAP;
          end else begin
            word_cnt <= word_cnt + WC_ONE;
          end
        end

        RD_WAIT, RD_BURST: begin
          if (mem_rd_data_valid) begin
            rd_data_out       <= mem_rd_data;
            rd_data_out_valid <= 1'b1;
            word_cnt          <= word_cnt + WC_ONE;
            if (word_cnt == WC_PENULT) begin
              // Done pulse lines up with the last registered read word.
              rd_burst_done <= 1'b1;
              state         <= GAP;
            end else begin
              state <= RD_BURST;
            end
          end else if (state == RD_WAIT) begin
            if (to_cnt == TO_LAST) begin
              error <= 1'b1;
              state <= GAP;
            end else begin
              to_cnt <= to_cnt + TO_ONE;
            end
          end
        end

        GAP: begin
          // Leave one cycle early so the next grant lands exactly CMD_CYCLES
          // after the previous one; at least one GAP cycle always occurs.
          if (cyc_cnt <= CYC_ONE) begin
            state <= init_done ? IDLE : INIT_WAIT;
          end
        end

        default: begin
          state <= INIT_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_access_arbiter.sv
// Self-checking bench for sdram_access_arbiter.
module tb_sdram_access_arbiter;
  import sdram_arb_pkg::*;

  localparam int AW = 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst;
  logic          init_done;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic          wr_gnt;
  logic [31:0]   wr_data_in;
  logic          wr_data_next;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic [31:0]   rd_data_out;
  logic          rd_data_out_valid;
  logic          rd_burst_done;
  logic          mem_cmd;
  logic          mem_cmd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [3:0]    mem_data_mask;
  logic [31:0]   mem_rd_data;
  logic          mem_rd_data_valid;
  logic          error;
  arb_state_t    dbg_state;

  sdram_access_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .init_done         (init_done),
    .wr_req            (wr_req),
    .wr_addr           (wr_addr),
    .wr_gnt            (wr_gnt),
    .wr_data_in        (wr_data_in),
    .wr_data_next      (wr_data_next),
    .rd_req            (rd_req),
    .rd_addr           (rd_addr),
    .rd_gnt            (rd_gnt),
    .rd_data_out       (rd_data_out),
    .rd_data_out_valid (rd_data_out_valid),
    .rd_burst_done     (rd_burst_done),
    .mem_cmd           (mem_cmd),
    .mem_cmd_en        (mem_cmd_en),
    .mem_addr          (mem_addr),
    .mem_wr_data       (mem_wr_data),
    .mem_data_mask     (mem_data_mask),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_data_valid (mem_rd_data_valid),
    .error             (error),
    .dbg_state         (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- driver helpers ----------------
  // Advance negedge by negedge until a command strobe is seen or budget ends.
  task automatic wait_cmd(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_cmd_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] strobes;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    strobes = {mem_cmd_en, wr_gnt, rd_gnt, wr_data_next,
               rd_data_out_valid, rd_burst_done, mem_cmd, error};
    checks++;
    if (strobes !== 8'h00) begin
      errors++; $display("FAIL reset_strobes: got %b expected 00000000", strobes);
    end
    checks++;
    if (mem_addr !== '0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr);
    end
    checks++;
    if (rd_data_out !== 32'h0) begin
      errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data_out);
    end
    checks++;
    if (mem_data_mask !== 4'b0000) begin
      errors++; $display("FAIL reset_mask: got %b expected 0000", mem_data_mask);
    end
    checks++;
    if (dbg_state !== INIT_WAIT) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, INIT_WAIT);
    end
  endtask

  task automatic test_init_wait();
    int n_cmd = 0;
    bit ok;
    rst = 1'b0; init_done = 1'b0; wr_req = 1'b1; wr_addr = 21'h012345;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_cmd_en) n_cmd++;
    end
    checks++;
    if (n_cmd != 0) begin
      errors++; $display("FAIL init_no_cmd: got %0d cmd_en expected 0", n_cmd);
    end
    checks++;
    if (dbg_state !== INIT_WAIT) begin
      errors++; $display("FAIL init_state: got %0d expected %0d", dbg_state, INIT_WAIT);
    end
    init_done = 1'b1;
    wait_cmd(3, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL init_first_cmd: got none expected cmd_en within 3 cycles");
    end else begin
      checks++;
      if (mem_cmd !== 1'b1 || wr_gnt !== 1'b1) begin
        errors++; $display("FAIL init_first_write: got cmd=%b gnt=%b expected 1 1", mem_cmd, wr_gnt);
      end
      checks++;
      if (mem_addr !== 21'h012345) begin
        errors++; $display("FAIL init_addr: got %h expected 012345", mem_addr);
      end
    end
    wr_req = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_write_burst();
    bit ok;
    bit adv;
    int idx = 0, nexts = 0, first_next = -1, last_next = -1, gnt_cyc = 0;
    logic [31:0] exp;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hA0 + i);
    wr_addr = 21'h096040; wr_data_in = 32'hA0; wr_req = 1'b1;
    wait_cmd(5, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL wr_grant: got no cmd_en expected a write grant");
      wr_req = 1'b0;
      return;
    end
    gnt_cyc = cyc;
    checks++;
    if (wr_gnt !== 1'b1 || rd_gnt !== 1'b0 || mem_cmd !== CMD_WRITE) begin
      errors++; $display("FAIL wr_gnt_coincide: got wr_gnt=%b rd_gnt=%b cmd=%b expected 1 0 1", wr_gnt, rd_gnt, mem_cmd);
    end
    checks++;
    if (mem_addr !== 21'h096040) begin
      errors++; $display("FAIL wr_addr: got %h expected 096040", mem_addr);
    end
    // Keep a follow-up write pending to measure command spacing.
    wr_addr = 21'h096060;
    for (int it = 0; it < 40 && nexts < 8; it++) begin
      adv = wr_data_next;
      if (wr_data_next) begin
        if (nexts == 0) first_next = cyc;
        last_next = cyc;
        nexts++;
        exp = exp_q.pop_front();
        checks++;
        if (mem_wr_data !== exp) begin
          errors++; $display("FAIL wr_data: got %h expected %h", mem_wr_data, exp);
        end
      end
      @(posedge clk); #1;
      if (adv) begin
        idx++;
        wr_data_in = 32'hA0 + idx;
      end
      @(negedge clk);
    end
    checks++;
    if (nexts != 8 || last_next - first_next != 7 || first_next != gnt_cyc) begin
      errors++; $display("FAIL wr_next_run: got count=%0d span=%0d start=%0d expected 8 7 %0d",
                         nexts, last_next - first_next, first_next, gnt_cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wr_words_left: got %0d expected 0", exp_q.size());
    end
    wait_cmd(30, ok);
    checks++;
    if (!ok || cyc - gnt_cyc < 19) begin
      errors++; $display("FAIL wr_spacing: got ok=%0d spacing=%0d expected >=19", ok, cyc - gnt_cyc);
    end
    wr_req = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_read_burst();
    bit ok;
    logic [31:0] mask;
    logic [31:0] data;
    logic [31:0] exp;
    bit prev_exp = 1'b0, prev_last = 1'b0;
    int nw = 0, n_out = 0, n_done = 0;
    mask = 32'h0012_7360;  // valids at 5,6,8,9,12,13,14,17 and a stray one at 20
    exp_q.delete();
    rd_addr = 21'h1ABCDE; rd_req = 1'b1;
    wait_cmd(5, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rd_grant: got no cmd_en expected a read grant");
      rd_req = 1'b0;
      return;
    end
    checks++;
    if (rd_gnt !== 1'b1 || wr_gnt !== 1'b0 || mem_cmd !== CMD_READ || mem_addr !== 21'h1ABCDE) begin
      errors++; $display("FAIL rd_gnt_coincide: got rd_gnt=%b cmd=%b addr=%h expected 1 0 1abcde", rd_gnt, mem_cmd, mem_addr);
    end
    rd_req = 1'b0;
    for (int k = 0; k < 26; k++) begin
      if (k > 0) begin
        checks++;
        if (rd_data_out_valid !== prev_exp) begin
          errors++; $display("FAIL rd_out_valid: k=%0d got %b expected %b", k, rd_data_out_valid, prev_exp);
        end
        checks++;
        if (rd_burst_done !== prev_last) begin
          errors++; $display("FAIL rd_done: k=%0d got %b expected %b", k, rd_burst_done, prev_last);
        end
        if (rd_burst_done) n_done++;
        if (rd_data_out_valid) begin
          n_out++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL rd_unexpected_word: got %h expected none", rd_data_out);
          end else begin
            exp = exp_q.pop_front();
            if (rd_data_out !== exp) begin
              errors++; $display("FAIL rd_data: got %h expected %h", rd_data_out, exp);
            end
          end
        end
      end
      prev_exp = 1'b0; prev_last = 1'b0;
      data = $urandom;
      mem_rd_data = data;
      mem_rd_data_valid = mask[k];
      if (mask[k] && nw < 8) begin
        exp_q.push_back(data);
        prev_exp = 1'b1;
        nw++;
        prev_last = (nw == 8);
      end
      @(negedge clk);
    end
    mem_rd_data_valid = 1'b0;
    checks++;
    if (n_out != 8 || n_done != 1 || exp_q.size() != 0) begin
      errors++; $display("FAIL rd_totals: got words=%0d done=%0d left=%0d expected 8 1 0", n_out, n_done, exp_q.size());
    end
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL rd_no_error: got %b expected 0", error);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic exp_cmd [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int ngr = 0, last_cmd = 0, resp_left = 0;
    logic [31:0] data;
    logic [31:0] exp;
    exp_q.delete();
    rd_addr = 21'h000100; wr_addr = 21'h000200;
    rd_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 400 && ngr < 10; i++) begin
      @(negedge clk);
      if (rd_data_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_word: got %h expected none", rd_data_out);
        end else begin
          exp = exp_q.pop_front();
          if (rd_data_out !== exp) begin
            errors++; $display("FAIL b2b_rd_data: got %h expected %h", rd_data_out, exp);
          end
        end
      end
      if (mem_cmd_en) begin
        checks++;
        if (mem_cmd !== exp_cmd[ngr]) begin
          errors++; $display("FAIL b2b_order: grant %0d got cmd=%b expected %b", ngr, mem_cmd, exp_cmd[ngr]);
        end
        checks++;
        if (wr_gnt !== mem_cmd || rd_gnt !== !mem_cmd) begin
          errors++; $display("FAIL b2b_gnt: grant %0d got wr=%b rd=%b expected wr=%b rd=%b", ngr, wr_gnt, rd_gnt, mem_cmd, !mem_cmd);
        end
        if (ngr > 0) begin
          checks++;
          if (cyc - last_cmd != 19) begin
            errors++; $display("FAIL b2b_spacing: grant %0d got %0d expected 19", ngr, cyc - last_cmd);
          end
        end
        last_cmd = cyc;
        if (mem_cmd == CMD_READ) resp_left = 8;
        ngr++;
      end
      if (resp_left > 0) begin
        data = $urandom;
        mem_rd_data = data;
        mem_rd_data_valid = 1'b1;
        exp_q.push_back(data);
        resp_left--;
      end else begin
        mem_rd_data_valid = 1'b0;
      end
    end
    rd_req = 1'b0; wr_req = 1'b0; mem_rd_data_valid = 1'b0;
    checks++;
    if (ngr != 10) begin
      errors++; $display("FAIL b2b_grants: got %0d expected 10", ngr);
    end
    repeat (25) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_words_left: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int first = -1;
    mem_rd_data_valid = 1'b0;
    rd_addr = 21'h0F0F0F; rd_req = 1'b1;
    wait_cmd(5, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL to_grant: got no cmd_en expected a read grant");
      rd_req = 1'b0;
      return;
    end
    rd_req = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (error === 1'b1 && first < 0) first = k;
    end
    checks++;
    if (first != 64) begin
      errors++; $display("FAIL to_error_time: got cycle %0d expected 64", first);
    end
    wr_addr = 21'h033333; wr_req = 1'b1;
    wait_cmd(40, ok);
    checks++;
    if (!ok || mem_cmd !== CMD_WRITE) begin
      errors++; $display("FAIL to_next_grant: got ok=%0d cmd=%b expected 1 1", ok, mem_cmd);
    end
    wr_req = 1'b0;
    repeat (25) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      errors++; $display("FAIL to_sticky: got %b expected 1", error);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int n_cmd = 0;
    logic [7:0] strobes;
    wr_addr = 21'h055555; wr_data_in = 32'hC0; wr_req = 1'b1;
    wait_cmd(5, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rstmid_grant: got no cmd_en expected a write grant");
      wr_req = 1'b0;
      return;
    end
    wr_req = 1'b0;
    repeat (3) @(negedge clk);   // fourth word is on the bus now
    rst = 1'b1;
    @(negedge clk);
    strobes = {mem_cmd_en, wr_gnt, rd_gnt, wr_data_next,
               rd_data_out_valid, rd_burst_done, mem_cmd, error};
    checks++;
    if (strobes !== 8'h00 || mem_addr !== '0 || rd_data_out !== 32'h0) begin
      errors++; $display("FAIL rstmid_outputs: got strobes=%b addr=%h rd=%h expected 0 0 0", strobes, mem_addr, rd_data_out);
    end
    checks++;
    if (dbg_state !== INIT_WAIT) begin
      errors++; $display("FAIL rstmid_state: got %0d expected %0d", dbg_state, INIT_WAIT);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_cmd_en) n_cmd++;
    end
    checks++;
    if (n_cmd != 0) begin
      errors++; $display("FAIL rstmid_no_cmd: got %0d cmd_en expected 0", n_cmd);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; init_done = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data_in = '0;
    rd_req = 1'b0; rd_addr = '0;
    mem_rd_data = '0; mem_rd_data_valid = 1'b0;
    test_reset();
    test_init_wait();
    test_write_burst();
    test_read_burst();
    test_back_to_back();
    test_timeout();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
